// File: rtl/uart_tx_frame_ctrl_if.sv
// rtl/uart_tx_frame_ctrl_if.sv - UART TX framing controller request/line interface
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_BIT;
    logic                  TX_OUT;
    logic                  BUSY;

    // Register-side driver: presents bytes and parity, observes the line
    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_BIT,
        input  TX_OUT,
        input  BUSY
    );

    // Serializer side: consumes requests, drives the line
    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_BIT,
        output TX_OUT,
        output BUSY
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit framing controller and serializer
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_tx_frame_ctrl_if.slave     bus
);
    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    // State, datapath and registered line outputs; reset aborts any frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // Next state plus the line value for that state, so outputs land on the entry edge
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.DATA_VALID) begin
                    state_d  = START;
                    shreg_d  = bus.P_DATA;
                    par_en_d = bus.PAR_EN;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                tx_d    = shreg_q[0];
                shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = bus.PAR_BIT;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
                busy_d  = 1'b1;
            end
            STOP: begin
                // Requests on this edge are dropped: one idle cycle separates frames
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.TX_OUT = tx_q;
    assign bus.BUSY   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - self-checking bench for uart_tx_frame_ctrl
module tb_uart_tx_frame_ctrl;
    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_frame_ctrl_if #(.DATA_WIDTH(W)) bus ();

    uart_tx_frame_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: a frame is a list of line bits; 2 marks the parity slot
    int q_bits[$];
    bit m_tx   = 1'b1;
    bit m_busy = 1'b0;

    typedef struct {
        logic [W-1:0] data;
        bit           par_en;
        bit           par_bit;
        int           len;
        logic [15:0]  seq;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        m_tx   = 1'b1;
        m_busy = 1'b0;
    endtask

    task automatic model_edge();
        int b;
        if (q_bits.size() > 0) begin
            b      = q_bits.pop_front();
            m_tx   = (b == 2) ? bus.PAR_BIT : b[0];
            m_busy = 1'b1;
        end else if (m_busy) begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else if (bus.DATA_VALID) begin
            m_tx   = 1'b0;
            m_busy = 1'b1;
            for (int i = 0; i < W; i++) q_bits.push_back(int'(bus.P_DATA[i]));
            if (bus.PAR_EN) q_bits.push_back(2);
            q_bits.push_back(1);
        end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    // One clock: model follows the edge, DUT compared on the falling edge
    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk("model_tx", 32'(bus.TX_OUT), 32'(m_tx));
        chk("model_busy", 32'(bus.BUSY), 32'(m_busy));
    endtask

    task automatic set_in(input logic dv, input logic [W-1:0] d, input logic pe, input logic pb);
        bus.DATA_VALID = dv;
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_BIT    = pb;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, par_en: 1'b1, par_bit: 1'b0, len: 11, seq: 16'h054A};
        vecs[1] = '{data: 8'h3C, par_en: 1'b0, par_bit: 1'b0, len: 10, seq: 16'h0278};
        vecs[2] = '{data: 8'h00, par_en: 1'b1, par_bit: 1'b1, len: 11, seq: 16'h0600};
        vecs[3] = '{data: 8'hFF, par_en: 1'b0, par_bit: 1'b1, len: 10, seq: 16'h03FE};

        set_in(1'b0, '0, 1'b0, 1'b0);
        RST = 1'b0;
        model_reset();
        #12;
        chk("reset_tx", 32'(bus.TX_OUT), 32'd1);
        chk("reset_busy", 32'(bus.BUSY), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_tx", 32'(bus.TX_OUT), 32'd1);
            chk("idle_busy", 32'(bus.BUSY), 32'd0);
        end

        // Table-driven frames with hand-computed line sequences
        for (int v = 0; v < 4; v++) begin
            set_in(1'b1, vecs[v].data, vecs[v].par_en, vecs[v].par_bit);
            for (int i = 0; i < vecs[v].len; i++) begin
                step();
                if (i == 0) set_in(1'b0, ~vecs[v].data, ~vecs[v].par_en, vecs[v].par_bit);
                chk($sformatf("vec%0d_tx%0d", v, i), 32'(bus.TX_OUT), 32'(vecs[v].seq[i]));
                chk($sformatf("vec%0d_busy%0d", v, i), 32'(bus.BUSY), 32'd1);
            end
            step();
            chk($sformatf("vec%0d_end_tx", v), 32'(bus.TX_OUT), 32'd1);
            chk($sformatf("vec%0d_end_busy", v), 32'(bus.BUSY), 32'd0);
            step();
        end

        // Request during DATA phase is ignored
        set_in(1'b1, 8'h0F, 1'b0, 1'b0);
        step();
        set_in(1'b0, 8'h0F, 1'b0, 1'b0);
        step();
        step();
        set_in(1'b1, 8'hFF, 1'b1, 1'b0);
        step();
        chk("ign_bit2", 32'(bus.TX_OUT), 32'd1);
        set_in(1'b0, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        chk("ign_bit6", 32'(bus.TX_OUT), 32'd0);
        step();
        step();
        chk("ign_stop", 32'(bus.TX_OUT), 32'd1);
        chk("ign_stop_busy", 32'(bus.BUSY), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ign_no_second", 32'(bus.BUSY), 32'd0);
        end

        // Back-to-back with DATA_VALID held high
        set_in(1'b1, 8'h55, 1'b0, 1'b0);
        step();
        set_in(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) step();
        chk("b2b_stop", 32'(bus.TX_OUT), 32'd1);
        chk("b2b_stop_busy", 32'(bus.BUSY), 32'd1);
        step();
        chk("b2b_gap_tx", 32'(bus.TX_OUT), 32'd1);
        chk("b2b_gap_busy", 32'(bus.BUSY), 32'd0);
        step();
        chk("b2b_start2", 32'(bus.TX_OUT), 32'd0);
        chk("b2b_start2_busy", 32'(bus.BUSY), 32'd1);
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("b2b_aa_bit0", 32'(bus.TX_OUT), 32'd0);
        step();
        chk("b2b_aa_bit1", 32'(bus.TX_OUT), 32'd1);
        for (int i = 0; i < 10; i++) step();

        // Reset during data bit 4
        set_in(1'b1, 8'hA5, 1'b1, 1'b0);
        step();
        set_in(1'b0, 8'hA5, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) step();
        chk("mid_bit4", 32'(bus.TX_OUT), 32'd0);
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_tx", 32'(bus.TX_OUT), 32'd1);
        chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_tx", 32'(bus.TX_OUT), 32'd1);
            chk("post_rst_busy", 32'(bus.BUSY), 32'd0);
        end

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step();
        chk("final_idle", 32'(bus.BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
